// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encodings, opcodes and IR capture pattern.
// JTAG_IDCODE_EN selects IDCODE (defined) or BYPASS (undefined) as the reset instruction.
package jtag_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_t;

    localparam logic [3:0] OPC_IDCODE         = 4'b0001;
    localparam logic [3:0] OPC_SAMPLE_PRELOAD = 4'b0010;
    localparam logic [3:0] OPC_EXTEST         = 4'b0011;
    localparam logic [3:0] OPC_INTEST         = 4'b0100;
    localparam logic [3:0] OPC_DMRESET        = 4'b1000;
    localparam logic [3:0] OPC_BYPASS         = 4'b1111;

    localparam logic [3:0] IR_CAPTURE_VAL = 4'b0101;

`ifdef JTAG_IDCODE_EN
    localparam logic [3:0] OPC_RESET = OPC_IDCODE;
`else
    localparam logic [3:0] OPC_RESET = OPC_BYPASS;
`endif

endpackage

// File: rtl/jtag_tap_fsm.sv
// TMS-driven 16-state TAP machine; exposes the current and next state so the
// instruction logic can react on the same edge that enters TEST_LOGIC_RESET.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       i_tck,
    input  logic       i_trst_n,
    input  logic       i_tms,
    output tap_state_t o_state,
    output tap_state_t o_state_next
);

    tap_state_t r_state;
    tap_state_t w_state_next;

    always_comb begin
        w_state_next = TEST_LOGIC_RESET;
        unique case (r_state)
            TEST_LOGIC_RESET: w_state_next = i_tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    w_state_next = i_tms ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_DR:        w_state_next = i_tms ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR:       w_state_next = i_tms ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:         w_state_next = i_tms ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:         w_state_next = i_tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:         w_state_next = i_tms ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:         w_state_next = i_tms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:        w_state_next = i_tms ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_IR:        w_state_next = i_tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       w_state_next = i_tms ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:         w_state_next = i_tms ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:         w_state_next = i_tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:         w_state_next = i_tms ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:         w_state_next = i_tms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:        w_state_next = i_tms ? SELECT_DR : RUN_TEST_IDLE;
            default:          w_state_next = TEST_LOGIC_RESET;
        endcase
    end

    always_ff @(posedge i_tck or negedge i_trst_n) begin
        if (!i_trst_n) begin
            r_state <= TEST_LOGIC_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign o_state      = r_state;
    assign o_state_next = w_state_next;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: IR, bypass/ID registers, BSR control decode and TDO mux.
// JTAG_IDCODE_EN adds the IDCODE opcode and 32-bit ID register.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic                tck,
    input  logic                trst,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    output logic                bsr_tdi,
    input  logic                bsr_tdo,
    output logic                bsr_capture,
    output logic                bsr_shift,
    output logic                bsr_update,
    output logic                bsr_mode,
    output logic                dm_reset,
    output logic [3:0]          tap_state,
    output logic [IR_WIDTH-1:0] ir_active
);

    localparam logic [IR_WIDTH-1:0] L_RESET   = IR_WIDTH'(OPC_RESET);
    localparam logic [IR_WIDTH-1:0] L_CAPTURE = IR_WIDTH'(IR_CAPTURE_VAL);

    tap_state_t          w_state;
    tap_state_t          w_state_next;
    logic [IR_WIDTH-1:0] r_ir_shift;
    logic [IR_WIDTH-1:0] r_ir_active;
    logic [IR_WIDTH-1:0] w_ir_active_next;
    logic                r_bypass;
    logic                r_bsr_mode;
    logic                r_dm_reset;
    logic                r_tdo;
    logic                r_tdo_en;
    logic                w_sel_bsr;
    logic                w_sel_id;
    logic                w_id_lsb;
    logic                w_tdo_next;

    jtag_tap_fsm u_fsm (
        .i_tck        (tck),
        .i_trst_n     (trst),
        .i_tms        (tms),
        .o_state      (w_state),
        .o_state_next (w_state_next)
    );

    // Entering TEST_LOGIC_RESET via TMS reloads the reset instruction on that same edge.
    always_comb begin
        w_ir_active_next = r_ir_active;
        if (w_state_next == TEST_LOGIC_RESET) begin
            w_ir_active_next = L_RESET;
        end else if (w_state == UPDATE_IR) begin
            w_ir_active_next = r_ir_shift;
        end
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            r_ir_shift  <= L_CAPTURE;
            r_ir_active <= L_RESET;
            r_bsr_mode  <= 1'b0;
            r_dm_reset  <= 1'b0;
            r_bypass    <= 1'b0;
        end else begin
            if (w_state == CAPTURE_IR) begin
                r_ir_shift <= L_CAPTURE;
            end else if (w_state == SHIFT_IR) begin
                r_ir_shift <= {tdi, r_ir_shift[IR_WIDTH-1:1]};
            end
            r_ir_active <= w_ir_active_next;
            r_bsr_mode  <= (w_ir_active_next == IR_WIDTH'(OPC_EXTEST)) ||
                           (w_ir_active_next == IR_WIDTH'(OPC_INTEST));
            r_dm_reset  <= (w_ir_active_next == IR_WIDTH'(OPC_DMRESET));
            if (w_state == CAPTURE_DR) begin
                r_bypass <= 1'b0;
            end else if (w_state == SHIFT_DR) begin
                r_bypass <= tdi;
            end
        end
    end

    assign w_sel_bsr = (r_ir_active == IR_WIDTH'(OPC_SAMPLE_PRELOAD)) ||
                       (r_ir_active == IR_WIDTH'(OPC_EXTEST)) ||
                       (r_ir_active == IR_WIDTH'(OPC_INTEST));

`ifdef JTAG_IDCODE_EN
    logic [31:0] r_idcode;

    assign w_sel_id = (r_ir_active == IR_WIDTH'(OPC_IDCODE));

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            r_idcode <= IDCODE_VAL;
        end else if (w_sel_id && (w_state == CAPTURE_DR)) begin
            r_idcode <= IDCODE_VAL;
        end else if (w_sel_id && (w_state == SHIFT_DR)) begin
            r_idcode <= {tdi, r_idcode[31:1]};
        end
    end

    assign w_id_lsb = r_idcode[0];
`else
    logic w_unused_idcode;

    assign w_unused_idcode = ^IDCODE_VAL;
    assign w_sel_id        = 1'b0;
    assign w_id_lsb        = 1'b0;
`endif

    always_comb begin
        w_tdo_next = 1'b0;
        if (w_state == SHIFT_IR) begin
            w_tdo_next = r_ir_shift[0];
        end else if (w_state == SHIFT_DR) begin
            w_tdo_next = w_sel_bsr ? bsr_tdo : (w_sel_id ? w_id_lsb : r_bypass);
        end
    end

    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end else begin
            r_tdo    <= w_tdo_next;
            r_tdo_en <= (w_state == SHIFT_IR) || (w_state == SHIFT_DR);
        end
    end

    assign tdo         = r_tdo;
    assign tdo_en      = r_tdo_en;
    assign bsr_tdi     = tdi;
    assign bsr_capture = (w_state == CAPTURE_DR) && w_sel_bsr;
    assign bsr_shift   = (w_state == SHIFT_DR)   && w_sel_bsr;
    assign bsr_update  = (w_state == UPDATE_DR)  && w_sel_bsr;
    assign bsr_mode    = r_bsr_mode;
    assign dm_reset    = r_dm_reset;
    assign tap_state   = w_state;
    assign ir_active   = r_ir_active;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl; expectations follow JTAG_IDCODE_EN when defined.
module tb_jtag_tap_ctrl;
    import jtag_pkg::*;

`ifdef JTAG_IDCODE_EN
    localparam logic [3:0] EXP_RST_IR = 4'b0001;
`else
    localparam logic [3:0] EXP_RST_IR = 4'b1111;
`endif

    logic       tck = 1'b0;
    logic       trst;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic       tdo_en;
    logic       bsr_tdi;
    logic       bsr_tdo;
    logic       bsr_capture;
    logic       bsr_shift;
    logic       bsr_update;
    logic       bsr_mode;
    logic       dm_reset;
    logic [3:0] tap_state;
    logic [3:0] ir_active;

    int checks = 0;
    int errors = 0;

    jtag_tap_ctrl #(.IR_WIDTH(4), .IDCODE_VAL(32'h1000_0001)) dut (
        .tck         (tck),
        .trst        (trst),
        .tms         (tms),
        .tdi         (tdi),
        .tdo         (tdo),
        .tdo_en      (tdo_en),
        .bsr_tdi     (bsr_tdi),
        .bsr_tdo     (bsr_tdo),
        .bsr_capture (bsr_capture),
        .bsr_shift   (bsr_shift),
        .bsr_update  (bsr_update),
        .bsr_mode    (bsr_mode),
        .dm_reset    (dm_reset),
        .tap_state   (tap_state),
        .ir_active   (ir_active)
    );

    always #5 tck = ~tck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive TMS/TDI, clock one posedge, then settle past the following negedge.
    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    // From RUN_TEST_IDLE: scan v into the IR and return to RUN_TEST_IDLE.
    task automatic load_ir(input logic [3:0] v, output logic [3:0] cap, output logic mode_upd);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        cap[0] = tdo;
        for (int i = 0; i < 4; i++) begin
            step(i == 3, v[i]);
            if (i < 3) cap[i+1] = tdo;
        end
        step(1'b1, 1'b0);
        mode_upd = bsr_mode;
        step(1'b0, 1'b0);
    endtask

    logic [31:0] word;
    logic [4:0]  got;
    logic [3:0]  cap;
    logic [3:0]  pat;
    logic [2:0]  bpat;
    logic        mode_upd;
    int          n_shift;
    int          n_upd;

    initial begin
        trst    = 1'b0;
        tms     = 1'b1;
        tdi     = 1'b0;
        bsr_tdo = 1'b0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("rst_state", tap_state, 4'hF);
        chk("rst_ir", ir_active, EXP_RST_IR);
        chk("rst_tdo_en", tdo_en, 0);
        chk("rst_tdo", tdo, 0);
        chk("rst_bsr", {bsr_capture, bsr_shift, bsr_update, bsr_mode, dm_reset}, 0);

        trst = 1'b1;
        repeat (5) step(1'b1, 1'b0);
        chk("tlr_hold_state", tap_state, 4'hF);
        chk("tlr_hold_ir", ir_active, EXP_RST_IR);

        step(1'b0, 1'b0);
        chk("rti_state", tap_state, 4'hC);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("shift_dr_state", tap_state, 4'h2);
        chk("shift_dr_tdo_en", tdo_en, 1);
`ifdef JTAG_IDCODE_EN
        word[0] = tdo;
        for (int i = 1; i < 32; i++) begin
            step(1'b0, 1'b0);
            word[i] = tdo;
        end
        chk("idcode_read", word, 32'h1000_0001);
`else
        chk("rst_byp_first", tdo, 0);
        pat = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, pat[i]);
            chk("rst_byp_delay", tdo, pat[i]);
        end
`endif
        step(1'b1, 1'b0);
        chk("exit1_state", tap_state, 4'h1);
        chk("exit1_tdo_en", tdo_en, 0);
        step(1'b0, 1'b0);
        chk("pause_state", tap_state, 4'h3);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("upd_dr_no_bsr", bsr_update, 0);
        step(1'b0, 1'b0);

        // BYPASS: 0 from capture, then tdi 1,0,1,1 delayed by one cycle.
        load_ir(4'b1111, cap, mode_upd);
        chk("ir_capture_out", cap, 4'b0101);
        chk("ir_bypass", ir_active, 4'b1111);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        got[0] = tdo;
        pat = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, pat[i]);
            got[i+1] = tdo;
        end
        chk("bypass_seq", got, 5'b11010);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // EXTEST: BSR controls and TDO from the chain.
        load_ir(4'b0011, cap, mode_upd);
        chk("mode_before_update", mode_upd, 0);
        chk("extest_mode", bsr_mode, 1);
        chk("extest_dmreset", dm_reset, 0);
        step(1'b1, 1'b0);
        chk("seldr_capture", bsr_capture, 0);
        step(1'b0, 1'b0);
        chk("bsr_capture", bsr_capture, 1);
        chk("bsr_shift_in_cap", bsr_shift, 0);
        bpat    = 3'b101;
        n_shift = 0;
        for (int i = 0; i < 3; i++) begin
            bsr_tdo = bpat[i];
            step(1'b0, i[0]);
            if (bsr_shift) n_shift++;
            chk("bsr_tdo_pass", tdo, bpat[i]);
        end
        chk("bsr_tdi_wire", bsr_tdi, tdi);
        step(1'b1, 1'b0);
        chk("exit1_bsr_shift", bsr_shift, 0);
        n_upd = 0;
        step(1'b1, 1'b0);
        if (bsr_update) n_upd++;
        step(1'b0, 1'b0);
        if (bsr_update) n_upd++;
        step(1'b0, 1'b0);
        if (bsr_update) n_upd++;
        chk("bsr_shift_cycles", n_shift, 3);
        chk("bsr_update_cycles", n_upd, 1);

        // DMRESET, then TMS reset clears it.
        load_ir(4'b1000, cap, mode_upd);
        chk("dmreset_on", dm_reset, 1);
        chk("dmreset_mode", bsr_mode, 0);
        repeat (5) step(1'b1, 1'b0);
        chk("dmreset_off", dm_reset, 0);
        chk("tms_reset_ir", ir_active, EXP_RST_IR);
        chk("tms_reset_state", tap_state, 4'hF);

        // trst in the middle of an IR shift.
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("mid_shift_state", tap_state, 4'hA);
        chk("mid_shift_tdo_en", tdo_en, 1);
        trst = 1'b0;
        #2;
        chk("abort_state", tap_state, 4'hF);
        chk("abort_tdo", tdo, 0);
        chk("abort_tdo_en", tdo_en, 0);
        chk("abort_ir", ir_active, EXP_RST_IR);
        step(1'b1, 1'b0);
        trst = 1'b1;
        step(1'b1, 1'b0);
        chk("after_abort_ir", ir_active, EXP_RST_IR);
        chk("after_abort_state", tap_state, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_tap_ctrl.md
# jtag_tap_ctrl

IEEE 1149.1 TAP controller for the drop-in JTAG test logic. It decodes TMS into the 16-state TAP machine and holds the instruction register, the bypass register and the IDCODE register. It drives the capture, shift and update controls and the mode select for the boundary-scan chain that wraps the RISC-V core. It also multiplexes the chain return onto TDO and asserts the debug-module reset.

## Interface
Parameters:
- IR_WIDTH, 4, instruction register width
- IDCODE_VAL, 32'h1000_0001, device ID; bit 0 must be 1

Ports:
- tck  in  1  JTAG clock; the only clock
- trst  in  1  asynchronous, active-low reset
- tms  in  1  mode select, sampled on posedge tck
- tdi  in  1  serial data in
- tdo  out  1  serial data out, changes on negedge tck
- tdo_en  out  1  high only while shifting IR or DR
- bsr_tdi  out  1  chain input, wired to tdi
- bsr_tdo  in  1  chain return
- bsr_capture  out  1  high in CAPTURE_DR when the BSR is selected
- bsr_shift  out  1  high in SHIFT_DR when the BSR is selected
- bsr_update  out  1  high in UPDATE_DR when the BSR is selected
- bsr_mode  out  1  high when the active instruction is EXTEST or INTEST
- dm_reset  out  1  high while the active instruction is DMRESET
- tap_state  out  4  current state, for debug
- ir_active  out  IR_WIDTH  latched instruction

## Operation
- States: TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR. The SELECT_IR…UPDATE_IR branch mirrors the DR branch.
- Transitions follow the 1149.1 standard:
  - SELECT_IR with tms=1 goes to TEST_LOGIC_RESET.
  - UPDATE_x goes to SELECT_DR on tms=1 and RUN_TEST_IDLE on tms=0.
  - TEST_LOGIC_RESET holds on tms=1.
- Five consecutive tms=1 edges reach TEST_LOGIC_RESET from any state.
- Opcodes:
  - IDCODE 0001 selects the 32-bit ID register.
  - SAMPLE_PRELOAD 0010, EXTEST 0011 and INTEST 0100 select the BSR.
  - DMRESET 1000 selects bypass.
  - BYPASS 1111 and every undefined opcode select bypass.
- IR shift register:
  - CAPTURE_IR loads 0101.
  - SHIFT_IR shifts right: tdi enters the MSB and the LSB goes to tdo.
  - UPDATE_IR copies the shift register to ir_active.
- In TEST_LOGIC_RESET, ir_active holds the reset instruction: IDCODE.
- Bypass register: captures 0 in CAPTURE_DR and loads tdi in SHIFT_DR, giving one cycle of delay.
- ID register: loads IDCODE_VAL in CAPTURE_DR and shifts LSB first in SHIFT_DR.
- bsr_capture, bsr_shift and bsr_update are decoded combinationally from the state register and the select, so they are glitch-free.
- TDO source:
  - In SHIFT_IR: IR LSB.
  - In SHIFT_DR: the selected DR (bypass, ID LSB or bsr_tdo).
  - Otherwise: 0, with tdo_en=0.
- dm_reset and bsr_mode change only when ir_active changes.

## Timing
- State, IR, bypass, ID and ir_active registers update on posedge tck.
- tdo and tdo_en are registered on negedge tck from the values present after that posedge.
- Reset values while trst=0 are applied asynchronously:
  - state TEST_LOGIC_RESET
  - ir_active = IDCODE; IR shift register = 0101
  - tdo=0, tdo_en=0
  - bsr_* = 0, bsr_mode=0, dm_reset=0
- Entering TEST_LOGIC_RESET through TMS has the same effect on ir_active as trst.
- A trst assertion mid-shift aborts the shift. ir_active is not updated.
- Bit timing:
  - The first TDO bit of a DR shift is valid after the negedge following the CAPTURE_DR→SHIFT_DR posedge.
  - The bit shifted on the EXIT1 transition edge is the last bit.
- PAUSE_x holds all shift registers unchanged.
- bsr_update is high for exactly one tck cycle per UPDATE_DR visit.

## Configuration
- JTAG_IDCODE_EN defined: IDCODE opcode and ID register are present, and the reset instruction is IDCODE.
- JTAG_IDCODE_EN undefined:
  - The ID register is removed.
  - Opcode 0001 decodes as BYPASS.
  - The reset instruction and ir_active reset value are BYPASS, so DR shifts after reset read 0 then tdi.

## Structure
- Package jtag_pkg holds:
  - the tap_state_t enum, using the standard 4-bit 1149.1 encodings;
  - the opcode localparams;
  - IR_CAPTURE_VAL = 4'b0101.
- One sub-module, jtag_tap_fsm: TMS-to-state logic only. The top of this block holds the registers, decode and TDO mux.

## Test plan
- trst low, then tms=1 for 5 tck → tap_state=TEST_LOGIC_RESET, ir_active=0001, all bsr_* = 0, tdo_en=0.
- Reset, go to SHIFT_DR, shift 32 bits → tdo returns 32'h1000_0001 LSB first. Without JTAG_IDCODE_EN → first bit 0, then tdi delayed one cycle.
- Load IR 1111, shift DR pattern 1011 → tdo shows 0,1,0,1,1 (one-cycle delay). IR shift from CAPTURE_IR emits 1,0,1,0.
- Load IR 0011 → bsr_mode=1 after UPDATE_IR. One DR scan gives bsr_capture=1, bsr_shift=1 for N cycles, bsr_update=1 for exactly 1 cycle. tdo follows bsr_tdo.
- Load IR 1000 → dm_reset=1. Then tms=1 ×5 → dm_reset=0 and ir_active=0001.
- Assert trst during SHIFT_IR after 2 bits → ir_active unchanged at reset value, state TEST_LOGIC_RESET, tdo=0.
